// File: rtl/board_shift_seq.sv
// Diagonal board-shift engine for the checkers move generator (shift/ray modes).
// Define BOARD_SHIFT_EARLY_EXIT_EN to stop a run as soon as the bitmap empties.
module board_shift_seq #(
    parameter int ROWS   = 8,
    parameter int COLS   = 4,
    parameter int STEP_W = 3,
    localparam int N     = ROWS * COLS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_board,
    input  logic [N-1:0]      in_block,
    input  logic [1:0]        in_dir,
    input  logic [STEP_W-1:0] in_steps,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_board,
    output logic [STEP_W-1:0] out_steps_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        dir_q;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] cnt_q;
    logic              mode_q;
    logic [N-1:0]      block_q;
    logic [N-1:0]      cur_q;
    logic [N-1:0]      acc_q;

    logic [N-1:0]      sh_ul, sh_ur, sh_dl, sh_dr;
    logic [N-1:0]      shifted;
    logic [N-1:0]      nxt_cur;
    logic [STEP_W-1:0] nxt_cnt;
    logic              stop;

    // Each destination square pulls from its unique source; rows alternate offset.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int I = r * COLS + c;
            if (r == 0) begin : g_no_dn
                assign sh_dr[I] = 1'b0;
                assign sh_dl[I] = 1'b0;
            end else if (r % 2 == 1) begin : g_dn_even_src
                assign sh_dr[I] = cur_q[I-COLS];
                if (c < COLS - 1) begin : g_dl
                    assign sh_dl[I] = cur_q[I-COLS+1];
                end else begin : g_dl0
                    assign sh_dl[I] = 1'b0;
                end
            end else begin : g_dn_odd_src
                assign sh_dl[I] = cur_q[I-COLS];
                if (c > 0) begin : g_dr
                    assign sh_dr[I] = cur_q[I-COLS-1];
                end else begin : g_dr0
                    assign sh_dr[I] = 1'b0;
                end
            end
            if (r == ROWS - 1) begin : g_no_up
                assign sh_ur[I] = 1'b0;
                assign sh_ul[I] = 1'b0;
            end else if (r % 2 == 0) begin : g_up_odd_src
                assign sh_ul[I] = cur_q[I+COLS];
                if (c > 0) begin : g_ur
                    assign sh_ur[I] = cur_q[I+COLS-1];
                end else begin : g_ur0
                    assign sh_ur[I] = 1'b0;
                end
            end else begin : g_up_even_src
                assign sh_ur[I] = cur_q[I+COLS];
                if (c < COLS - 1) begin : g_ul
                    assign sh_ul[I] = cur_q[I+COLS+1];
                end else begin : g_ul0
                    assign sh_ul[I] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        shifted = '0;
        unique case (dir_q)
            2'd0: shifted = sh_ul;
            2'd1: shifted = sh_ur;
            2'd2: shifted = sh_dl;
            2'd3: shifted = sh_dr;
            default: shifted = '0;
        endcase
    end

    assign nxt_cur = mode_q ? (shifted & ~block_q) : shifted;
    assign nxt_cnt = cnt_q + STEP_W'(1);

`ifdef BOARD_SHIFT_EARLY_EXIT_EN
    assign stop = (nxt_cnt == steps_q) || (nxt_cur == '0);
`else
    assign stop = (nxt_cnt == steps_q);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            dir_q   <= '0;
            steps_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            block_q <= '0;
            cur_q   <= '0;
            acc_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dir_q   <= in_dir;
                        steps_q <= in_steps;
                        mode_q  <= in_mode;
                        block_q <= in_block;
                        cur_q   <= in_board;
                        acc_q   <= in_board;
                        cnt_q   <= '0;
                        state   <= (in_steps == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cur_q <= nxt_cur;
                    if (mode_q) begin
                        acc_q <= acc_q | nxt_cur;
                    end
                    cnt_q <= nxt_cnt;
                    if (stop) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready       = (state == IDLE);
    assign out_valid      = (state == DONE);
    assign out_board      = out_valid ? (mode_q ? acc_q : cur_q) : '0;
    assign out_steps_done = out_valid ? cnt_q : '0;

endmodule

// File: tb/tb_board_shift_seq.sv
// Directed vector bench for board_shift_seq (default 8x4 board, 3-bit steps).
// Expected step counts follow BOARD_SHIFT_EARLY_EXIT_EN when it is defined.
module tb_board_shift_seq;

`ifdef BOARD_SHIFT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_board = '0;
    logic [31:0] in_block = '0;
    logic [1:0]  in_dir = '0;
    logic [2:0]  in_steps = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_board;
    logic [2:0]  out_steps_done;

    int n_checks = 0;
    int n_fail = 0;

    board_shift_seq #(.ROWS(8), .COLS(4), .STEP_W(3)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_board(in_board),
        .in_block(in_block),
        .in_dir(in_dir),
        .in_steps(in_steps),
        .in_mode(in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_board(out_board),
        .out_steps_done(out_steps_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] board;
        logic [31:0] block;
        logic [1:0]  dir;
        logic [2:0]  steps;
        logic        mode;
        logic [31:0] exp_board;
        logic [2:0]  exp_full;
        logic [2:0]  exp_early;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat;
        logic [2:0] exp_done;
        exp_done = EE ? v.exp_early : v.exp_full;
        @(negedge clock);
        chk({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        in_board = v.board;
        in_block = v.block;
        in_dir   = v.dir;
        in_steps = v.steps;
        in_mode  = v.mode;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_board = 32'hDEAD_BEEF;
        in_block = 32'hFFFF_FFFF;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_done));
        chk({tag, " board"}, out_board, v.exp_board);
        chk({tag, " steps_done"}, {29'd0, out_steps_done}, {29'd0, exp_done});
        chk({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int seen;
        //          board         block         dir   st    md    exp_board     full  early
        vecs[0]  = '{32'h0000_0001, 32'h0, 2'd3, 3'd1, 1'b0, 32'h0000_0010, 3'd1, 3'd1};
        vecs[1]  = '{32'h0000_0010, 32'h0, 2'd3, 3'd2, 1'b0, 32'h0000_2000, 3'd2, 3'd2};
        vecs[2]  = '{32'h8000_0000, 32'h0, 2'd0, 3'd1, 1'b0, 32'h0800_0000, 3'd1, 3'd1};
        vecs[3]  = '{32'h0000_0100, 32'h0, 2'd2, 3'd4, 1'b0, 32'h0000_0000, 3'd4, 3'd1};
        vecs[4]  = '{32'h8000_0000, 32'h0, 2'd1, 3'd1, 1'b0, 32'h0000_0000, 3'd1, 3'd1};
        vecs[5]  = '{32'h0000_0001, 32'h0, 2'd3, 3'd7, 1'b1, 32'h8844_2211, 3'd7, 3'd7};
        vecs[6]  = '{32'h0000_0001, 32'h0000_2000, 2'd3, 3'd7, 1'b1, 32'h0000_0211, 3'd7, 3'd3};
        vecs[7]  = '{32'hA5A5_0F0F, 32'h0, 2'd1, 3'd0, 1'b0, 32'hA5A5_0F0F, 3'd0, 3'd0};
        vecs[8]  = '{32'h0000_0001, 32'h0000_0010, 2'd3, 3'd1, 1'b0, 32'h0000_0010, 3'd1, 3'd1};
        vecs[9]  = '{32'h0000_0F00, 32'h0, 2'd1, 3'd1, 1'b0, 32'h0000_00F0, 3'd1, 3'd1};
        vecs[10] = '{32'h0000_00FF, 32'h0, 2'd2, 3'd1, 1'b0, 32'h0000_0F70, 3'd1, 3'd1};
        vecs[11] = '{32'h0000_000F, 32'h0, 2'd0, 3'd1, 1'b0, 32'h0000_0000, 3'd1, 3'd1};
        vecs[12] = '{32'h8000_0000, 32'h0, 2'd0, 3'd3, 1'b1, 32'h8844_0000, 3'd3, 3'd3};
        vecs[13] = '{32'h0000_0001, 32'h0, 2'd3, 3'd7, 1'b0, 32'h8000_0000, 3'd7, 3'd7};

        repeat (2) @(posedge clock);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_board", out_board, 32'd0);
        chk("reset steps_done", {29'd0, out_steps_done}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while requests are ignored.
        @(negedge clock);
        in_board = 32'h1; in_block = '0; in_dir = 2'd3;
        in_steps = 3'd1; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 40) begin
            @(posedge clock);
            #1;
            seen++;
        end
        chk("bp reach done", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            in_valid = k[0] ? 1'b0 : 1'b1;
            in_board = 32'h0F0F_0F0F;
            in_steps = 3'd5;
            @(posedge clock);
            #1;
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp board", out_board, 32'h10);
            chk("bp steps_done", {29'd0, out_steps_done}, 32'd1);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge clock);
        #1;
        chk("bp no ghost op", {31'd0, in_ready}, 32'd1);
        do_op(vecs[1], "bp next");

        // Reset during RUN discards the op.
        @(negedge clock);
        in_board = 32'h1; in_block = '0; in_dir = 2'd3;
        in_steps = 3'd7; in_mode = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rst mid busy", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("rst mid in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst mid out_board", out_board, 32'd0);
        chk("rst mid steps_done", {29'd0, out_steps_done}, 32'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        chk("rst mid no output", 32'(seen), 32'd0);
        v = vecs[7];
        do_op(v, "rst next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
